// File: rtl/cmp_serial_seq.sv
// Bit-serial MSB-first unsigned magnitude comparator. It takes one bit pair per
// valid beat and pulses done with registered EQ/GT/LT once N bits have been taken.
module cmp_serial_seq #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic EQ,
  output logic GT,
  output logic LT
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_dec, r_gt, r_lt;
  logic          r_done, r_eq_f, r_gt_f, r_lt_f;

  logic w_accept, w_last, w_gt_nxt, w_lt_nxt, w_dec_nxt;

  // start has priority over a bit pair that arrives in the same cycle
  assign w_accept  = (r_state == SHIFT) && !start && bit_valid;
  assign w_last    = w_accept && (r_cnt == LAST);
  // The first differing bit from the MSB end fixes the result. Later bits are only counted.
  assign w_gt_nxt  = r_dec ? r_gt : (a_bit & ~b_bit);
  assign w_lt_nxt  = r_dec ? r_lt : (~a_bit & b_bit);
  assign w_dec_nxt = r_dec | (a_bit ^ b_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (start) w_state_nxt = SHIFT;
               else if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dec  <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
      r_done <= 1'b0;
      r_eq_f <= 1'b0;
      r_gt_f <= 1'b0;
      r_lt_f <= 1'b0;
    end else if (start) begin
      r_cnt  <= '0;
      r_dec  <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
      r_done <= 1'b0;
      r_eq_f <= 1'b0;
      r_gt_f <= 1'b0;
      r_lt_f <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
        r_dec <= w_dec_nxt;
        r_gt  <= w_gt_nxt;
        r_lt  <= w_lt_nxt;
      end
      if (w_last) begin
        r_gt_f <= w_gt_nxt;
        r_lt_f <= w_lt_nxt;
        r_eq_f <= ~(w_gt_nxt | w_lt_nxt);
      end
    end
  end

  always_comb begin
    busy = (r_state == SHIFT);
    done = r_done;
    EQ   = r_eq_f;
    GT   = r_gt_f;
    LT   = r_lt_f;
  end

endmodule

// File: tb/tb_cmp_serial_seq.sv
// Bench for cmp_serial_seq: a table of vectors, hand-written corner sequences, and
// random operands checked against plain integer comparison (N=4 and N=8 instances).
module tb_cmp_serial_seq;

  logic clk = 1'b0;
  logic rst_n, start, bit_valid, a_bit, b_bit;
  logic busy4, done4, eq4, gt4, lt4;
  logic busy8, done8, eq8, gt8, lt8;
  int   n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  cmp_serial_seq #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy4), .done(done4),
    .EQ(eq4), .GT(gt4), .LT(lt4));

  cmp_serial_seq #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy8), .done(done8),
    .EQ(eq8), .GT(gt8), .LT(lt8));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       eq, gt, lt;
  } vec_t;

  // {busy, done, EQ, GT, LT} for the instance of width w
  function automatic logic [4:0] outs(input int w);
    if (w == 8) return {busy8, done8, eq8, gt8, lt8};
    return {busy4, done4, eq4, gt4, lt4};
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {busy,done,EQ,GT,LT}=%b, expected %b", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; bit_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Stream w bits MSB first, optionally with random gaps, then check the done cycle
  // and the cycle after it.
  task automatic run(input string nm, input int w, input logic [7:0] a, input logic [7:0] b,
                     input bit gaps, input logic [2:0] exp_flags);
    int g;
    do_start();
    chk({nm, " busy"}, outs(w), 5'b10000);
    for (int i = w - 1; i >= 0; i--) begin
      g = 0;
      while (gaps && g < 3 && $urandom_range(0, 2) == 0) begin
        bit_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
        tick();
        g++;
      end
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      tick();
    end
    bit_valid = 1'b0;
    chk({nm, " done"}, outs(w), {2'b01, exp_flags});
    tick();
    chk({nm, " hold"}, outs(w), {2'b00, exp_flags});
  endtask

  function automatic logic [2:0] model(input int a, input int b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  initial begin
    vec_t tbl[6];
    logic [7:0] ra, rb;
    logic [6:0] vpat;
    logic [3:0] ga, gb;
    int k, ndone;

    tbl[0] = '{a: 4'b1010, b: 4'b1010, eq: 1'b1, gt: 1'b0, lt: 1'b0};
    tbl[1] = '{a: 4'b1100, b: 4'b1011, eq: 1'b0, gt: 1'b1, lt: 1'b0};
    tbl[2] = '{a: 4'b0001, b: 4'b0000, eq: 1'b0, gt: 1'b1, lt: 1'b0};
    tbl[3] = '{a: 4'b0111, b: 4'b1000, eq: 1'b0, gt: 1'b0, lt: 1'b1};
    tbl[4] = '{a: 4'b0000, b: 4'b1111, eq: 1'b0, gt: 1'b0, lt: 1'b1};
    tbl[5] = '{a: 4'b1111, b: 4'b1110, eq: 1'b0, gt: 1'b1, lt: 1'b0};

    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    tick(); tick();
    chk("reset n4", outs(4), 5'b00000);
    chk("reset n8", outs(8), 5'b00000);
    rst_n = 1'b1;
    tick();
    // bit_valid while idle must be ignored
    bit_valid = 1'b1; a_bit = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("idle ignores bits", outs(4), 5'b00000);

    for (int i = 0; i < 6; i++)
      run($sformatf("tbl%0d", i), 4, {4'b0, tbl[i].a}, {4'b0, tbl[i].b}, 1'b0,
          {tbl[i].eq, tbl[i].gt, tbl[i].lt});

    // LT fixed at the MSB, bit_valid pattern 1,0,0,1,0,1,1, later bits a=1/b=0
    ga = 4'b0111; gb = 4'b1000; vpat = 7'b1001011; k = 3;
    do_start();
    for (int i = 6; i >= 0; i--) begin
      bit_valid = vpat[i];
      a_bit = vpat[i] ? ga[k] : 1'b1;
      b_bit = vpat[i] ? gb[k] : 1'b0;
      if (vpat[i]) k--;
      tick();
      if (i > 0) chk("gap no early done", outs(4), 5'b10000);
    end
    bit_valid = 1'b0;
    chk("gap LT done", outs(4), 5'b01001);

    // abort after 2 bits; restart coincides with a valid bit that must not count
    do_start();
    for (int i = 0; i < 2; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0; tick();
    end
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    tick();
    start = 1'b0;
    ga = 4'b0000; gb = 4'b0011; ndone = 0;
    for (int i = 3; i >= 0; i--) begin
      bit_valid = 1'b1; a_bit = ga[i]; b_bit = gb[i];
      tick();
      if (done4) ndone++;
      if (i == 1) chk("abort no done after 3", outs(4), 5'b10000);
    end
    bit_valid = 1'b0;
    chk("abort LT", outs(4), 5'b01001);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done4) ndone++;
    end
    chk("abort one pulse", {2'b0, 3'(ndone)}, 5'd1);

    // asynchronous reset mid-comparison, then a fresh equal compare
    do_start();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0; tick();
    end
    bit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", outs(4), 5'b00000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("no done after reset", outs(4), 5'b00000);
    run("post reset eq", 4, 8'h05, 8'h05, 1'b0, 3'b100);
    // reset also clears held flags
    rst_n = 1'b0; #1;
    chk("reset clears flags", outs(4), 5'b00000);
    rst_n = 1'b1; tick();

    // N=8: flags hold through idle cycles, then start clears them
    run("n8 80>7f", 8, 8'h80, 8'h7F, 1'b0, 3'b010);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (outs(8) != 5'b00010) ndone++;
    end
    chk("n8 20 idle hold", {2'b0, 3'(ndone)}, 5'd0);
    do_start();
    chk("n8 start clears", outs(8), 5'b10000);
    tick();
    chk("n8 busy no bits", outs(8), 5'b10000);

    // random operands with random gaps against integer comparison
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      if (i % 2 == 0) begin
        ra[7:4] = 4'b0; rb[7:4] = 4'b0;
        run($sformatf("rnd4 %0h/%0h", ra, rb), 4, ra, rb, 1'b1, model(int'(ra), int'(rb)));
      end else
        run($sformatf("rnd8 %0h/%0h", ra, rb), 8, ra, rb, 1'b1, model(int'(ra), int'(rb)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
